// File: rtl/cache_ctrl_fsm_pkg.sv
// Shared types and address-field constants for the direct-mapped write-back data cache.
// Package cache_def is imported by the controller and its word-merge helper.
package cache_def;

  localparam int NUM_SETS    = 512;
  localparam int BLOCK_WORDS = 4;
  localparam int TAG_W       = 19;
  localparam int INDEX_W     = 9;
  localparam int OFFSET_W    = 4;
  localparam int LINE_W      = 32 * BLOCK_WORDS;
  localparam int WORD_SEL_W  = $clog2(BLOCK_WORDS);

  localparam int TAG_MSB   = 31;
  localparam int TAG_LSB   = 13;
  localparam int INDEX_MSB = 12;
  localparam int INDEX_LSB = 4;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               we;
  } cache_req_type;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_type;

  typedef logic [LINE_W-1:0] cache_data_type;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE
  } cache_state_e;

  // Latched CPU request; the byte offset within a word is never needed.
  typedef struct packed {
    logic        rw;
    logic [31:2] addr;
    logic [31:0] wdata;
  } cpu_req_type;

endpackage

// File: rtl/cache_word_merge.sv
// Combinational insert of one 32-bit word into a cache line at the selected word slot.
module cache_word_merge
  import cache_def::*;
(
  input  cache_data_type        line_i,
  input  logic [31:0]           word_i,
  input  logic [WORD_SEL_W-1:0] sel_i,
  output cache_data_type        line_o
);

  always_comb begin
    line_o = line_i;
    line_o[{sel_i, 5'd0} +: 32] = word_i;
  end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Controller FSM for the direct-mapped write-back, write-allocate data cache.
// Define CACHE_STATS_EN to build the 32-bit hit/miss counters; otherwise they read as 0.
module cache_ctrl_fsm
  import cache_def::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cpu_valid_i,
  input  logic           cpu_rw_i,
  input  logic [31:0]    cpu_addr_i,
  input  logic [31:0]    cpu_wdata_i,
  output logic [31:0]    cpu_rdata_o,
  output logic           cpu_ready_o,
  output logic           mem_valid_o,
  output logic           mem_rw_o,
  output logic [31:0]    mem_addr_o,
  output logic [127:0]   mem_wdata_o,
  input  logic [127:0]   mem_rdata_i,
  input  logic           mem_ready_i,
  output cache_req_type  tag_req_o,
  output cache_tag_type  tag_write_o,
  input  cache_tag_type  tag_read_i,
  output cache_req_type  data_req_o,
  output cache_data_type data_write_o,
  input  cache_data_type data_read_i,
  output logic [31:0]    hit_cnt_o,
  output logic [31:0]    miss_cnt_o
);

  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUM_SETS - 1);

  cache_state_e       state_q;
  logic [INDEX_W-1:0] init_idx_q;
  cpu_req_type        req_q;
  logic               cpu_ready_q;
  logic [31:0]        cpu_rdata_q;
  logic               mem_valid_q;
  logic               mem_rw_q;
  logic [31:0]        mem_addr_q;
  cache_data_type     mem_wdata_q;

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic [31:0]        rd_word;
  cache_data_type     merged_line;
  logic               unused_addr_bits;

  assign req_index        = req_q.addr[INDEX_MSB:INDEX_LSB];
  assign req_tag          = req_q.addr[TAG_MSB:TAG_LSB];
  assign hit              = tag_read_i.valid && (tag_read_i.tag == req_tag);
  assign rd_word          = data_read_i[{req_q.addr[3:2], 5'd0} +: 32];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  cache_word_merge u_merge (
    .line_i (data_read_i),
    .word_i (req_q.wdata),
    .sel_i  (req_q.addr[3:2]),
    .line_o (merged_line)
  );

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      init_idx_q  <= '0;
      req_q       <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      case (state_q)
        INIT: begin
          init_idx_q <= init_idx_q + 1'b1;
          if (init_idx_q == LAST_INDEX) state_q <= IDLE;
        end
        IDLE: begin
          if (cpu_valid_i) begin
            req_q   <= '{rw: cpu_rw_i, addr: cpu_addr_i[31:2], wdata: cpu_wdata_i};
            state_q <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            cpu_ready_q <= 1'b1;
            if (!req_q.rw) cpu_rdata_q <= rd_word;
            state_q     <= IDLE;
          end else if (tag_read_i.valid && tag_read_i.dirty) begin
            mem_valid_q <= 1'b1;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= {tag_read_i.tag, req_index, {OFFSET_W{1'b0}}};
            mem_wdata_q <= data_read_i;
            state_q     <= WRITE_BACK;
          end else begin
            mem_valid_q <= 1'b1;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= {req_tag, req_index, {OFFSET_W{1'b0}}};
            state_q     <= ALLOCATE;
          end
        end
        WRITE_BACK: begin
          // The fill request follows the write-back without a gap in mem_valid_o.
          if (mem_ready_i) begin
            mem_rw_q   <= 1'b0;
            mem_addr_q <= {req_tag, req_index, {OFFSET_W{1'b0}}};
            state_q    <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            state_q     <= COMPARE;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Array strobes are combinational so the write lands on the edge that ends the state;
  // gating with rst_i guarantees no partial write while reset is asserted.
  always_comb begin
    // NOTE: defaults first so every field is assigned on every path; this prevents latches.
    tag_req_o    = '0;
    tag_write_o  = '0;
    data_req_o   = '0;
    data_write_o = '0;
    if (!rst_i) begin
      tag_req_o.index  = (state_q == INIT) ? init_idx_q : req_index;
      data_req_o.index = req_index;
      case (state_q)
        INIT: tag_req_o.we = 1'b1;
        COMPARE: begin
          if (hit && req_q.rw) begin
            data_req_o.we = 1'b1;
            data_write_o  = merged_line;
            tag_req_o.we  = 1'b1;
            tag_write_o   = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
          end
        end
        ALLOCATE: begin
          if (mem_ready_i) begin
            data_req_o.we = 1'b1;
            data_write_o  = mem_rdata_i;
            tag_req_o.we  = 1'b1;
            tag_write_o   = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ready_o = cpu_ready_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_rw_o    = mem_rw_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        first_cmp_q;

  // Only the first COMPARE of an access is scored; the post-fill retry is not.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      first_cmp_q <= 1'b0;
    end else if (state_q == IDLE && cpu_valid_i) begin
      first_cmp_q <= 1'b1;
    end else if (state_q == COMPARE) begin
      first_cmp_q <= 1'b0;
      if (first_cmp_q) begin
        if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
        else     miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm with behavioural tag/data arrays and a hand-driven memory bus.
// Counter expectations follow CACHE_STATS_EN.
module tb_cache_ctrl_fsm;
  import cache_def::*;

  logic           clk;
  logic           rst_i;
  logic           cpu_valid;
  logic           cpu_rw;
  logic [31:0]    cpu_addr;
  logic [31:0]    cpu_wdata;
  logic [31:0]    cpu_rdata;
  logic           cpu_ready;
  logic           mem_valid;
  logic           mem_rw;
  logic [31:0]    mem_addr;
  logic [127:0]   mem_wdata;
  logic [127:0]   mem_rdata;
  logic           mem_ready;
  cache_req_type  tag_req;
  cache_tag_type  tag_wr;
  cache_tag_type  tag_rd;
  cache_req_type  data_req;
  cache_data_type data_wr;
  cache_data_type data_rd;
  logic [31:0]    hit_cnt;
  logic [31:0]    miss_cnt;

  int checks = 0;
  int errors = 0;
  int stats_on;

  cache_tag_type  tag_mem  [NUM_SETS];
  cache_data_type data_mem [NUM_SETS];

  localparam cache_data_type L1   = 128'h44444444_33333333_22222222_11111111;
  localparam cache_data_type L1_M = 128'h44444444_DEADBEEF_22222222_11111111;
  localparam cache_data_type L2   = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam cache_data_type L3   = 128'h55555555_66666666_77777777_88888888;

  cache_ctrl_fsm dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cpu_valid_i  (cpu_valid),
    .cpu_rw_i     (cpu_rw),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_ready_o  (cpu_ready),
    .mem_valid_o  (mem_valid),
    .mem_rw_o     (mem_rw),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ready_i  (mem_ready),
    .tag_req_o    (tag_req),
    .tag_write_o  (tag_wr),
    .tag_read_i   (tag_rd),
    .data_req_o   (data_req),
    .data_write_o (data_wr),
    .data_read_i  (data_rd),
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tag_rd  = tag_mem[tag_req.index];
  assign data_rd = data_mem[data_req.index];

  always @(posedge clk) begin
    if (tag_req.we)  tag_mem[tag_req.index]   <= tag_wr;
    if (data_req.we) data_mem[data_req.index] <= data_wr;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_mem_req(input string name, input logic exp_rw, input logic [31:0] exp_addr);
    checks++;
    if ({mem_valid, mem_rw, mem_addr} !== {1'b1, exp_rw, exp_addr}) begin
      errors++;
      $display("FAIL %s: valid/rw/addr got %b/%b/%h expected 1/%b/%h",
               name, mem_valid, mem_rw, mem_addr, exp_rw, exp_addr);
    end
  endtask

  task automatic check_ready(input string name, input logic exp_ready, input logic [31:0] exp_rdata);
    checks++;
    if (cpu_ready !== exp_ready || (exp_ready && cpu_rdata !== exp_rdata)) begin
      errors++;
      $display("FAIL %s: ready/rdata got %b/%h expected %b/%h",
               name, cpu_ready, cpu_rdata, exp_ready, exp_rdata);
    end
  endtask

  task automatic check_stats(input string name, input int exp_hit, input int exp_miss);
    logic [31:0] eh, em;
    eh = (stats_on != 0) ? 32'(exp_hit) : 32'd0;
    em = (stats_on != 0) ? 32'(exp_miss) : 32'd0;
    checks++;
    if (hit_cnt !== eh || miss_cnt !== em) begin
      errors++;
      $display("FAIL %s: hit/miss got %0d/%0d expected %0d/%0d", name, hit_cnt, miss_cnt, eh, em);
    end
  endtask

  task automatic init_sweep(input string name);
    int bad = 0;
    int valid_lines = 0;
    for (int k = 0; k < NUM_SETS; k++) begin
      if (tag_req.we !== 1'b1 || tag_req.index !== INDEX_W'(k) || tag_wr !== '0 ||
          data_req.we !== 1'b0 || cpu_ready !== 1'b0 || mem_valid !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_sweep: %0d bad cycles expected 0", name, bad);
    end
    checks++;
    if (tag_req.we !== 1'b0 || data_req.we !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: tag_we/data_we got %b/%b expected 0/0", name, tag_req.we, data_req.we);
    end
    for (int k = 0; k < NUM_SETS; k++) if (tag_mem[k].valid !== 1'b0) valid_lines++;
    checks++;
    if (valid_lines != 0) begin
      errors++;
      $display("FAIL %s_invalid: %0d valid lines expected 0", name, valid_lines);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    checks++;
    if ({cpu_ready, cpu_rdata, mem_valid, mem_rw, mem_addr, mem_wdata} !== '0 ||
        {tag_req, tag_wr, data_req, data_wr, hit_cnt, miss_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b mem_valid=%b tag_we=%b data_we=%b hit=%0d miss=%0d expected all 0",
               cpu_ready, mem_valid, tag_req.we, data_req.we, hit_cnt, miss_cnt);
    end
    rst_i = 1'b0;
    #1;
    init_sweep("init");
  endtask

  task automatic test_load_miss();
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h0000_0010;
    step();
    cpu_valid = 1'b0;
    check_ready("miss_no_early_ready", 1'b0, 32'h0);
    step();
    check_mem_req("miss_alloc_req", 1'b0, 32'h0000_0010);
    step();
    check_mem_req("miss_alloc_held", 1'b0, 32'h0000_0010);
    mem_rdata = L1; mem_ready = 1'b1;
    #1;
    checks++;
    if (data_req.we !== 1'b1 || data_wr !== L1 || tag_req.we !== 1'b1 ||
        tag_wr !== '{valid: 1'b1, dirty: 1'b0, tag: 19'd0} || tag_req.index !== 9'd1) begin
      errors++;
      $display("FAIL fill_write: data_we=%b data=%h tag_we=%b tag=%h idx=%0d expected 1/%h/1/%h/1",
               data_req.we, data_wr, tag_req.we, tag_wr, tag_req.index, L1, {2'b10, 19'd0});
    end
    step();
    mem_ready = 1'b0;
    checks++;
    if (mem_valid !== 1'b0 || cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_drop: mem_valid/ready got %b/%b expected 0/0", mem_valid, cpu_ready);
    end
    step();
    check_ready("miss_ready", 1'b1, 32'h1111_1111);
    step();
    check_ready("miss_ready_pulse", 1'b0, 32'h0);
    check_stats("miss_stats", 0, 1);
  endtask

  task automatic test_load_hit();
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h0000_0014;
    step();
    cpu_valid = 1'b0;
    check_ready("hit_not_yet", 1'b0, 32'h0);
    step();
    check_ready("hit_ready", 1'b1, 32'h2222_2222);
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL hit_no_mem: mem_valid got %b expected 0", mem_valid);
    end
    step();
    check_stats("hit_stats", 1, 1);
  endtask

  task automatic test_store_hit();
    cpu_valid = 1'b1; cpu_rw = 1'b1; cpu_addr = 32'h0000_0018; cpu_wdata = 32'hDEAD_BEEF;
    step();
    cpu_valid = 1'b0; cpu_rw = 1'b0; cpu_wdata = 32'h0;
    checks++;
    if (data_req.we !== 1'b1 || data_wr !== L1_M || tag_req.we !== 1'b1 ||
        tag_wr !== '{valid: 1'b1, dirty: 1'b1, tag: 19'd0}) begin
      errors++;
      $display("FAIL store_write: data_we=%b data=%h tag_we=%b tag=%h expected 1/%h/1/%h",
               data_req.we, data_wr, tag_req.we, tag_wr, L1_M, {2'b11, 19'd0});
    end
    step();
    check_ready("store_ready", 1'b1, cpu_rdata);
    checks++;
    if (data_mem[1] !== L1_M || tag_mem[1] !== '{valid: 1'b1, dirty: 1'b1, tag: 19'd0}) begin
      errors++;
      $display("FAIL store_arrays: line=%h tag=%h expected %h/%h", data_mem[1], tag_mem[1], L1_M, {2'b11, 19'd0});
    end
    check_stats("store_stats", 2, 1);
    step();
  endtask

  task automatic test_dirty_miss();
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h0000_2010;
    step();
    cpu_valid = 1'b0;
    checks++;
    if (tag_req.we !== 1'b0 || data_req.we !== 1'b0) begin
      errors++;
      $display("FAIL miss_no_write: tag_we/data_we got %b/%b expected 0/0", tag_req.we, data_req.we);
    end
    step();
    check_mem_req("wb_req", 1'b1, 32'h0000_0010);
    checks++;
    if (mem_wdata !== L1_M) begin
      errors++;
      $display("FAIL wb_data: got %h expected %h", mem_wdata, L1_M);
    end
    check_stats("wb_stats", 2, 2);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (data_req.we !== 1'b0 || tag_req.we !== 1'b0) begin
      errors++;
      $display("FAIL wb_no_write: tag_we/data_we got %b/%b expected 0/0", tag_req.we, data_req.we);
    end
    step();
    mem_ready = 1'b0;
    check_mem_req("wb_then_alloc", 1'b0, 32'h0000_2010);
    step();
    mem_rdata = L2; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    check_ready("wb_miss_ready", 1'b1, 32'hAAAA_0000);
    checks++;
    if (tag_mem[1] !== '{valid: 1'b1, dirty: 1'b0, tag: 19'd1} || data_mem[1] !== L2) begin
      errors++;
      $display("FAIL wb_refill: tag=%h line=%h expected %h/%h", tag_mem[1], data_mem[1], {2'b10, 19'd1}, L2);
    end
    step();
  endtask

  task automatic test_reset_mid_alloc();
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h0000_4010;
    step();
    cpu_valid = 1'b0;
    step();
    check_mem_req("clean_alloc_req", 1'b0, 32'h0000_4010);
    rst_i = 1'b1; mem_rdata = L3; mem_ready = 1'b1;
    #1;
    checks++;
    if (tag_req.we !== 1'b0 || data_req.we !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_write: tag_we/data_we got %b/%b expected 0/0", tag_req.we, data_req.we);
    end
    step();
    rst_i = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_abandon: mem_valid got %b expected 0", mem_valid);
    end
    check_stats("rst_stats", 0, 0);
    init_sweep("reinit");
    checks++;
    if (data_mem[1] !== L2) begin
      errors++;
      $display("FAIL rst_no_fill: line=%h expected %h", data_mem[1], L2);
    end
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h0000_0010;
    step();
    cpu_valid = 1'b0;
    step();
    check_mem_req("post_rst_miss", 1'b0, 32'h0000_0010);
    check_stats("post_rst_stats", 0, 1);
  endtask

  initial begin
`ifdef CACHE_STATS_EN
    stats_on = 1;
`else
    stats_on = 0;
`endif
    for (int k = 0; k < NUM_SETS; k++) begin
      tag_mem[k]  = '{valid: 1'b1, dirty: 1'b1, tag: '1};
      data_mem[k] = '1;
    end
    rst_i = 1'b1; cpu_valid = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_dirty_miss();
    test_reset_mid_alloc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
